// File: rtl/pcap_stream_arbiter.sv
// pcap_stream_arbiter: packet-granular round-robin merge of NUM_SRC pcap replay streams.
// Ports: clk/rst (async active-high); enable gates new grants only;
//   s_data/s_strb/s_valid/s_sop/s_eop in, s_ready out: per-source streams, source i in slice i;
//   m_data/m_strb/m_valid/m_sop/m_eop out, m_ready in: merged stream (zero-latency pass-through);
//   src_id: granted source; pkt_total: wrapping count of forwarded packets; proto_err: sticky violation flag.
module pcap_stream_arbiter #(
    parameter int AXIS_WIDTH = 64,
    parameter int NUM_SRC    = 4,
    parameter int MIN_IFG    = 0,
    parameter int SRC_W      = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             enable,
    input  logic [NUM_SRC*AXIS_WIDTH-1:0]    s_data,
    input  logic [NUM_SRC*AXIS_WIDTH/8-1:0]  s_strb,
    input  logic [NUM_SRC-1:0]               s_valid,
    input  logic [NUM_SRC-1:0]               s_sop,
    input  logic [NUM_SRC-1:0]               s_eop,
    output logic [NUM_SRC-1:0]               s_ready,
    output logic [AXIS_WIDTH-1:0]            m_data,
    output logic [AXIS_WIDTH/8-1:0]          m_strb,
    output logic                             m_valid,
    output logic                             m_sop,
    output logic                             m_eop,
    input  logic                             m_ready,
    output logic [SRC_W-1:0]                 src_id,
    output logic [15:0]                      pkt_total,
    output logic                             proto_err
);
    localparam int SW = AXIS_WIDTH / 8;

    typedef enum logic [1:0] {IDLE, STREAM, GAP} state_t;

    state_t           state_q, state_d;
    logic [SRC_W-1:0] grant_q, grant_d, last_q, last_d;
    logic [7:0]       gap_q, gap_d;
    logic [15:0]      total_q, total_d;
    logic             err_q, err_d, first_q, first_d, pend_q, pend_d;
    logic [NUM_SRC-1:0] elig;
    logic [SRC_W-1:0] pick_hi, pick_lo, pick;
    logic             found_hi, hs;

    assign elig      = s_valid & s_sop;
    assign src_id    = grant_q;
    assign pkt_total = total_q;
    assign proto_err = err_q;
    assign hs        = m_valid && m_ready;

    // Descending scan leaves the lowest eligible index above last_q in pick_hi,
    // and the lowest eligible index at or below last_q in pick_lo (wrap-around).
    always_comb begin
        found_hi = 1'b0;
        pick_hi  = '0;
        pick_lo  = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (elig[i] && i > int'(last_q)) begin
                found_hi = 1'b1;
                pick_hi  = SRC_W'(i);
            end
            if (elig[i] && i <= int'(last_q))
                pick_lo = SRC_W'(i);
        end
        pick = found_hi ? pick_hi : pick_lo;
    end

    always_comb begin
        m_data  = '0;
        m_strb  = '0;
        m_valid = 1'b0;
        m_sop   = 1'b0;
        m_eop   = 1'b0;
        s_ready = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (state_q == STREAM && grant_q == SRC_W'(i)) begin
                m_data     = s_data[i*AXIS_WIDTH +: AXIS_WIDTH];
                m_strb     = s_strb[i*SW +: SW];
                m_valid    = s_valid[i];
                m_sop      = s_sop[i];
                m_eop      = s_eop[i];
                s_ready[i] = m_ready;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        gap_d   = gap_q;
        total_d = total_q;
        err_d   = err_q;
        first_d = first_q;
        pend_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable && |elig) begin
                    grant_d = pick;
                    last_d  = pick;
                    first_d = 1'b1;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                // pend_q: a beat was offered while stalled and has not been taken yet
                err_d   = err_q | (hs && m_sop && !first_q) | (pend_q && !m_valid);
                pend_d  = m_valid && !m_ready;
                first_d = hs ? 1'b0 : first_q;
                if (hs && m_eop) begin
                    total_d = total_q + 16'd1;
                    gap_d   = 8'(MIN_IFG);
                    state_d = (MIN_IFG > 0) ? GAP : IDLE;
                end
            end
            GAP: begin
                gap_d   = gap_q - 8'd1;
                state_d = (gap_q == 8'd1) ? IDLE : GAP;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= SRC_W'(NUM_SRC - 1);
            gap_q   <= '0;
            total_q <= '0;
            err_q   <= 1'b0;
            first_q <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            gap_q   <= gap_d;
            total_q <= total_d;
            err_q   <= err_d;
            first_q <= first_d;
            pend_q  <= pend_d;
        end
    end
endmodule
